// File: rtl/noc_rr_arbiter_pkg.sv
// Shared NoC arbiter types, constants and the packet-length to beat-count helper.
package noc_rr_arbiter_pkg;

  localparam int unsigned NOC_BEAT_BYTES = 16;
  localparam int unsigned NOC_NUM_IN     = 4;
  localparam int unsigned NOC_DATA_W     = 128;
  localparam int unsigned NOC_LEN_W      = 16;
  localparam int unsigned NOC_BEATS_W    = NOC_LEN_W + 1;

  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    logic [NOC_LEN_W-1:0]  length;
  } NOCDataH;

  // max(1, ceil(len / 2**shift)); one extra bit so 65535 rounds up without wrapping
  function automatic logic [NOC_BEATS_W-1:0] noc_beats_from_len(
    input logic [NOC_LEN_W-1:0] len,
    input logic [4:0]           shift
  );
    logic [NOC_BEATS_W-1:0] w_round;
    logic [NOC_BEATS_W-1:0] w_beats;
    w_round = {1'b0, len} + ((NOC_BEATS_W'(1) << shift) - NOC_BEATS_W'(1));
    w_beats = w_round >> shift;
    if (w_beats == '0) w_beats = NOC_BEATS_W'(1);
    return w_beats;
  endfunction

endpackage

// File: rtl/noc_in_slot.sv
// One-entry input holding slot; can be drained and refilled in the same cycle.
module noc_in_slot
  import noc_rr_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_enq_ena,
  input  NOCDataH i_enq_data,
  input  logic    i_deq,
  output logic    o_enq_rdy_c,
  output logic    o_valid,
  output NOCDataH o_data
);

  logic    r_valid;
  NOCDataH r_data;
  logic    w_accept;

  assign o_enq_rdy_c = !r_valid || i_deq;
  assign w_accept    = i_enq_ena && o_enq_rdy_c;
  assign o_valid     = r_valid;
  assign o_data      = r_data;

  // enqueue while not ready is dropped; a new beat wins over the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= i_enq_data;
    end else if (i_deq) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Four-input round-robin NoC arbiter with packet locking.
// Define NOC_ARB_STATS_EN to add per-input header-transfer counters (pktCount0..3).
module noc_rr_arbiter
  import noc_rr_arbiter_pkg::*;
#(
  parameter int unsigned BEAT_BYTES = NOC_BEAT_BYTES,
  parameter int unsigned CNT_W      = 13
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in0_enq_ena,
  input  NOCDataH     in0_enq_v,
  output logic        in0_enq_rdy_c,
  input  logic        in1_enq_ena,
  input  NOCDataH     in1_enq_v,
  output logic        in1_enq_rdy_c,
  input  logic        in2_enq_ena,
  input  NOCDataH     in2_enq_v,
  output logic        in2_enq_rdy_c,
  input  logic        in3_enq_ena,
  input  NOCDataH     in3_enq_v,
  output logic        in3_enq_rdy_c,
  output logic        out_enq_ena_c,
  output NOCDataH     out_enq_v_c,
  input  logic        out_enq_rdy,
  output logic        busy,
  output logic [1:0]  owner
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [31:0] pktCount0,
  output logic [31:0] pktCount1,
  output logic [31:0] pktCount2,
  output logic [31:0] pktCount3
`endif
);

  localparam logic [4:0] LP_SHIFT = 5'($clog2(BEAT_BYTES));

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [1:0]             r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0]             r_owner, w_owner_nxt;
  logic [CNT_W-1:0]       r_remaining, w_remaining_nxt;

  logic                   w_enq_ena  [NOC_NUM_IN];
  NOCDataH                w_enq_data [NOC_NUM_IN];
  logic                   w_enq_rdy  [NOC_NUM_IN];
  logic                   w_valid    [NOC_NUM_IN];
  NOCDataH                w_data     [NOC_NUM_IN];
  logic                   w_deq      [NOC_NUM_IN];
  logic [1:0]             w_sel;
  logic                   w_found;
  logic                   w_xfer;
  logic [NOC_BEATS_W-1:0] w_beats;

  assign w_enq_ena[0]  = in0_enq_ena;
  assign w_enq_ena[1]  = in1_enq_ena;
  assign w_enq_ena[2]  = in2_enq_ena;
  assign w_enq_ena[3]  = in3_enq_ena;
  assign w_enq_data[0] = in0_enq_v;
  assign w_enq_data[1] = in1_enq_v;
  assign w_enq_data[2] = in2_enq_v;
  assign w_enq_data[3] = in3_enq_v;
  assign in0_enq_rdy_c = w_enq_rdy[0];
  assign in1_enq_rdy_c = w_enq_rdy[1];
  assign in2_enq_rdy_c = w_enq_rdy[2];
  assign in3_enq_rdy_c = w_enq_rdy[3];

  for (genvar k = 0; k < NOC_NUM_IN; k++) begin : g_slot
    assign w_deq[k] = w_xfer && (w_sel == 2'(k));
    noc_in_slot u_slot (
      .clk         (CLK),
      .rst_n       (nRST),
      .i_enq_ena   (w_enq_ena[k]),
      .i_enq_data  (w_enq_data[k]),
      .i_deq       (w_deq[k]),
      .o_enq_rdy_c (w_enq_rdy[k]),
      .o_valid     (w_valid[k]),
      .o_data      (w_data[k])
    );
  end

  // Selection: locked owner, else first valid slot after the last winner
  always_comb begin
    w_sel   = r_owner;
    w_found = 1'b0;
    if (r_state == ST_IDLE) begin
      for (int i = 1; i <= 4; i++) begin
        if (!w_found && w_valid[r_rr_ptr + 2'(i)]) begin
          w_sel   = r_rr_ptr + 2'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_xfer        = w_valid[w_sel] && out_enq_rdy;
  assign w_beats       = noc_beats_from_len(w_data[w_sel].length, LP_SHIFT);
  assign out_enq_ena_c = w_xfer;
  assign out_enq_v_c   = w_data[w_sel];
  assign busy          = (r_state == ST_LOCKED);
  assign owner         = r_owner;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 2'd3;
      r_owner     <= 2'd0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_remaining_nxt = r_remaining;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_rr_ptr_nxt = w_sel;
          if (w_beats != NOC_BEATS_W'(1)) begin
            w_state_nxt     = ST_LOCKED;
            w_owner_nxt     = w_sel;
            w_remaining_nxt = CNT_W'(w_beats - NOC_BEATS_W'(1));
          end
        end
      end
      ST_LOCKED: begin
        if (w_xfer) begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state_nxt     = ST_IDLE;
            w_owner_nxt     = 2'd0;
            w_remaining_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef NOC_ARB_STATS_EN
  logic [31:0] r_pkt_cnt [NOC_NUM_IN];

  // Header transfers only: the first beat taken while unlocked
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NOC_NUM_IN; i++) r_pkt_cnt[i] <= '0;
    end else if (w_xfer && (r_state == ST_IDLE)) begin
      r_pkt_cnt[w_sel] <= r_pkt_cnt[w_sel] + 32'd1;
    end
  end

  assign pktCount0 = r_pkt_cnt[0];
  assign pktCount1 = r_pkt_cnt[1];
  assign pktCount2 = r_pkt_cnt[2];
  assign pktCount3 = r_pkt_cnt[3];
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed scoreboard bench for noc_rr_arbiter; per-input expected-beat queues.
module tb_noc_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic         ena [4];
  logic [143:0] v   [4];
  logic         rdy [4];
  logic         out_ena;
  logic [143:0] out_v;
  logic         out_rdy;
  logic         busy;
  logic [1:0]   owner;
`ifdef NOC_ARB_STATS_EN
  logic [31:0]  pkt_cnt [4];
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [143:0] q0[$];
  logic [143:0] q1[$];
  logic [143:0] q2[$];
  logic [143:0] q3[$];

  noc_rr_arbiter dut (
    .CLK           (clk),
    .nRST          (rst_n),
    .in0_enq_ena   (ena[0]),
    .in0_enq_v     (v[0]),
    .in0_enq_rdy_c (rdy[0]),
    .in1_enq_ena   (ena[1]),
    .in1_enq_v     (v[1]),
    .in1_enq_rdy_c (rdy[1]),
    .in2_enq_ena   (ena[2]),
    .in2_enq_v     (v[2]),
    .in2_enq_rdy_c (rdy[2]),
    .in3_enq_ena   (ena[3]),
    .in3_enq_v     (v[3]),
    .in3_enq_rdy_c (rdy[3]),
    .out_enq_ena_c (out_ena),
    .out_enq_v_c   (out_v),
    .out_enq_rdy   (out_rdy),
    .busy          (busy),
    .owner         (owner)
`ifdef NOC_ARB_STATS_EN
    ,
    .pktCount0     (pkt_cnt[0]),
    .pktCount1     (pkt_cnt[1]),
    .pktCount2     (pkt_cnt[2]),
    .pktCount3     (pkt_cnt[3])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [143:0] beat(input int k, input int seq, input logic [15:0] len);
    return {8'(k), 24'(seq), 96'h0123_4567_89AB_CDEF_0011_2233, len};
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic [143:0] d);
    ena[k] = 1'b1;
    v[k]   = d;
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [143:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    case (k)
      0: if (q0.size() > 0) d = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) d = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) d = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) d = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic cyc(input bit e_ena, input int e_src, input bit e_busy, input logic [1:0] e_owner);
    logic [143:0] exp_d;
    bit           ok;
    #1;
    for (int k = 0; k < 4; k++) if (ena[k]) chk("in_rdy", 144'(rdy[k]), 144'(1'b1));
    chk("out_ena", 144'(out_ena), 144'(e_ena));
    if (e_ena && out_ena) begin
      pop_exp(e_src, exp_d, ok);
      chk("scoreboard_nonempty", 144'(ok), 144'(1'b1));
      if (ok) chk("out_data", out_v, exp_d);
    end
    chk("busy", 144'(busy), 144'(e_busy));
    chk("owner", 144'(owner), 144'(e_owner));
    @(negedge clk);
    for (int k = 0; k < 4; k++) ena[k] = 1'b0;
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) ena[k] = 1'b0;
    #1;
    chk("rst_out_ena", 144'(out_ena), 144'(1'b0));
    chk("rst_busy", 144'(busy), 144'(1'b0));
    chk("rst_owner", 144'(owner), 144'(2'd0));
    for (int k = 0; k < 4; k++) chk("rst_in_rdy", 144'(rdy[k]), 144'(1'b1));
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ena[k] = 1'b0;
      v[k]   = '0;
    end
    @(negedge clk);
    reset_and_check();

    // All four single-beat packets at once: served 0,1,2,3 back to back
    for (int k = 0; k < 4; k++) put(k, beat(k, 1, 16'd16));
    cyc(0, 0, 0, 2'd0);
    for (int k = 0; k < 4; k++) cyc(1, k, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);

    // Move the pointer to 1, then a 3-beat packet on in2 wins over a waiting in0
    put(1, beat(1, 2, 16'd16));
    cyc(0, 0, 0, 2'd0);
    cyc(1, 1, 0, 2'd0);
    out_rdy = 1'b0;
    put(0, beat(0, 2, 16'd16));
    put(2, beat(2, 2, 16'd48));
    cyc(0, 0, 0, 2'd0);
    out_rdy = 1'b1;
    put(2, beat(2, 3, 16'h1234));
    cyc(1, 2, 0, 2'd0);
    put(2, beat(2, 4, 16'hFFFF));
    cyc(1, 2, 1, 2'd2);
    cyc(1, 2, 1, 2'd2);
    cyc(1, 0, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);

    // 4-beat packet on in3 stalled 5 cycles with remaining==2, in1 waiting
    put(3, beat(3, 1, 16'd64));
    cyc(0, 0, 0, 2'd0);
    put(3, beat(3, 2, 16'd0));
    cyc(1, 3, 0, 2'd0);
    put(3, beat(3, 3, 16'd0));
    put(1, beat(1, 3, 16'd16));
    cyc(1, 3, 1, 2'd3);
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rdy3", 144'(rdy[3]), 144'(1'b0));
      chk("stall_rdy1", 144'(rdy[1]), 144'(1'b0));
      cyc(0, 0, 1, 2'd3);
    end
    out_rdy = 1'b1;
    put(3, beat(3, 4, 16'd0));
    cyc(1, 3, 1, 2'd3);
    cyc(1, 3, 1, 2'd3);
    cyc(1, 1, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);

    // Length 0 -> 1 beat, length 17 -> 2 beats
    put(0, beat(0, 3, 16'd0));
    cyc(0, 0, 0, 2'd0);
    put(0, beat(0, 4, 16'd17));
    cyc(1, 0, 0, 2'd0);
    put(0, beat(0, 5, 16'd0));
    cyc(1, 0, 0, 2'd0);
    cyc(1, 0, 1, 2'd0);
    cyc(0, 0, 0, 2'd0);

    // Length 65535 -> 4096 beats, streamed without a gap
    put(1, beat(1, 0, 16'hFFFF));
    cyc(0, 0, 0, 2'd0);
    for (int i = 0; i < 4096; i++) begin
      if (i < 4095) put(1, beat(1, i + 1, 16'h5A5A));
      cyc(1, 1, (i > 0), (i > 0) ? 2'd1 : 2'd0);
    end
    cyc(0, 0, 0, 2'd0);

    // Reset after beat 2 of a 4-beat packet, then a fresh packet on in1
    put(2, beat(2, 10, 16'd64));
    cyc(0, 0, 0, 2'd0);
    put(2, beat(2, 11, 16'd0));
    cyc(1, 2, 0, 2'd0);
    put(2, beat(2, 12, 16'd0));
    cyc(1, 2, 1, 2'd2);
    reset_and_check();
    put(1, beat(1, 20, 16'd8));
    cyc(0, 0, 0, 2'd0);
    cyc(1, 1, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);

    // Three single-beat packets on in3 from a clean reset
    reset_and_check();
    put(3, beat(3, 30, 16'd16));
    cyc(0, 0, 0, 2'd0);
    put(3, beat(3, 31, 16'd16));
    cyc(1, 3, 0, 2'd0);
    put(3, beat(3, 32, 16'd16));
    cyc(1, 3, 0, 2'd0);
    cyc(1, 3, 0, 2'd0);
    cyc(0, 0, 0, 2'd0);
`ifdef NOC_ARB_STATS_EN
    #1;
    chk("pkt_cnt0", 144'(pkt_cnt[0]), 144'(32'd0));
    chk("pkt_cnt1", 144'(pkt_cnt[1]), 144'(32'd0));
    chk("pkt_cnt2", 144'(pkt_cnt[2]), 144'(32'd0));
    chk("pkt_cnt3", 144'(pkt_cnt[3]), 144'(32'd3));
`endif

    chk("leftover_beats", 144'(q0.size() + q1.size() + q2.size() + q3.size()), 144'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter BEAT_BYTES, default 16, bytes of payload per beat; SHALL be a power of two no larger than 16.
REQ-002 Parameter CNT_W, default 13, width of the beats-remaining counter; SHALL be at least 13.
REQ-003 One clock and one asynchronous active-low reset: CLK input 1 is the clock; nRST input 1 is the reset, active low.
REQ-004 inK$enq__ENA input 1, K=0..3: requester K enqueues a beat.
REQ-005 inK$enq$v input 144, K=0..3: NOCDataH beat, {data[127:0], length[15:0]}.
REQ-006 inK$enq__RDY output 1, K=0..3: requester K may enqueue.
REQ-007 out$enq__ENA output 1: beat presented downstream.
REQ-008 out$enq$v output 144: beat value.
REQ-009 out$enq__RDY input 1: downstream accepts.
REQ-010 busy output 1: packet lock held.
REQ-011 owner output 2: index of the locked requester; 0 when not busy.

Function
REQ-012 Each input SHALL have a one-entry slot (valid bit plus 144-bit data); inK$enq__RDY = !validK || (selected==K && out$enq__RDY).
REQ-013 inK$enq__ENA asserted while inK$enq__RDY is low is a protocol error; the block SHALL ignore it.
REQ-014 out$enq__ENA = valid[sel] && out$enq__RDY; out$enq$v = slot[sel] (combinational, zero added latency from slot).
REQ-015 States IDLE and LOCKED.
REQ-016 IDLE: sel = first valid slot searching rr_ptr+1, rr_ptr+2, ... modulo 4; no valid slot means no output.
REQ-017 Header transfer in IDLE: rr_ptr <= sel; beats = max(1, ceil(length/BEAT_BYTES)); beats==1 stays IDLE; otherwise go LOCKED with owner<=sel and remaining<=beats-1.
REQ-018 LOCKED: sel = owner only; other valid slots SHALL wait; each transfer decrements remaining; transfer with remaining==1 returns to IDLE.
REQ-019 Arbitration in the cycle after the last beat SHALL be combinational, giving zero bubble between packets.
REQ-020 A slot being drained and refilled in the same cycle SHALL hold the new beat next cycle with no loss or duplication.
REQ-021 Length 0 SHALL count as one beat; length 65535 SHALL count as 4096 beats, with no counter overflow.
REQ-022 The length field of non-header beats SHALL be ignored and forwarded unchanged.
REQ-023 Beat order from each requester SHALL be preserved, and beats of different packets SHALL never interleave.

Reset
REQ-024 nRST low SHALL asynchronously clear all valid bits, set state IDLE, rr_ptr=3 (input 0 first), remaining=0, owner=0.
REQ-025 During reset, out$enq__ENA=0, busy=0, owner=0, inK$enq__RDY=1.
REQ-026 Reset mid-packet SHALL discard the held packet; downstream framing recovery is the sink's responsibility.

Configuration
REQ-027 With macro NOC_ARB_STATS_EN defined, four outputs pktCountK (32 bits each) SHALL count header transfers per input, reset to 0 and wrapping at 2^32.
REQ-028 Without NOC_ARB_STATS_EN, the pktCountK ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-029 A shared package SHALL hold the NOCDataH typedef, NOC_BEAT_BYTES=16, NOC_NUM_IN=4, and the beats-from-length function.
REQ-030 The per-input slot SHALL be a sub-module, noc_in_slot, instantiated four times; arbitration and the FSM SHALL sit in the top module.

Verification
REQ-031 After reset, in0..in3 each send one beat (length 16) in the same cycle with out RDY=1: output order SHALL be 0,1,2,3, one beat per cycle, busy=0 throughout.
REQ-032 in2 sends length 48 (3 beats) while in0 holds a valid beat: three in2 beats SHALL leave consecutively with busy=1 and owner=2, then in0's beat SHALL leave next cycle.
REQ-033 out$enq__RDY held low for 5 cycles while LOCKED with remaining=2: no output, state held, in-owner RDY=0; SHALL resume on release.
REQ-034 Length 0 and length 17 headers: SHALL produce 1 beat and 2 beats respectively.
REQ-035 nRST asserted after beat 2 of a 4-beat packet: outputs SHALL match REQ-025 immediately; a new 1-beat packet from in1 after release SHALL pass.
REQ-036 Under NOC_ARB_STATS_EN, 3 packets on in3 SHALL give pktCount3=3 and all other counts 0.
